// File: rtl/sequence_transmitter_if.sv
// Control/data bundle for sequence_transmitter: start/abort/repeat request in,
// serial stream plus status out.
interface sequence_transmitter_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             seq;
  logic             seq_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_cnt, abort,
    input  seq, seq_valid, busy, done
  );

  modport slave (
    input  start, repeat_cnt, abort,
    output seq, seq_valid, busy, done
  );
endinterface

// File: rtl/sequence_transmitter.sv
// Shifts a fixed pattern out MSB-first, repeated repeat_cnt times with GAP zero
// cycles between frames. All outputs are registered.
module sequence_transmitter #(
  parameter int unsigned        PAT_LEN = 6,
  parameter logic [PAT_LEN-1:0] PATTERN = 6'b110110,
  parameter int unsigned        GAP     = 1,
  parameter int unsigned        CNT_W   = 4
) (
  input logic                   clk,
  input logic                   rst,
  sequence_transmitter_if.slave bus
);

  localparam int unsigned BIT_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int unsigned GAP_W = 3;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_LEN - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               seq_q, seq_d;
  logic               seq_valid_q, seq_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    seq_d       = 1'b0;
    seq_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;

    if (bus.abort) begin
      state_d     = StIdle;
      shreg_d     = '0;
      bit_cnt_d   = '0;
      frame_cnt_d = '0;
      gap_cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (bus.start) begin
            if (bus.repeat_cnt != '0) begin
              state_d     = StShift;
              frame_cnt_d = bus.repeat_cnt;
              load        = 1'b1;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
        StShift: begin
          if (bit_cnt_q != LAST_BIT) begin
            seq_d       = shreg_q[PAT_LEN-1];
            shreg_d     = shreg_q << 1;
            bit_cnt_d   = bit_cnt_q + 1'b1;
            seq_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            // Last bit of this frame is on the wire now; decide what follows it.
            bit_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q - 1'b1;
            if (frame_cnt_q == CNT_W'(1)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else if (GAP != 0) begin
              state_d   = StGap;
              gap_cnt_d = '0;
              busy_d    = 1'b1;
            end else begin
              load = 1'b1;
            end
          end
        end
        StGap: begin
          busy_d = 1'b1;
          if (gap_cnt_q == LAST_GAP) begin
            state_d   = StShift;
            gap_cnt_d = '0;
            load      = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Start of a frame: first bit goes out next cycle, rest wait in the shifter.
    if (load) begin
      seq_d       = PATTERN[PAT_LEN-1];
      shreg_d     = PATTERN << 1;
      bit_cnt_d   = '0;
      seq_valid_d = 1'b1;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      gap_cnt_q   <= '0;
      seq_q       <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_q       <= seq_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.seq       = seq_q;
  assign bus.seq_valid = seq_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sequence_transmitter.sv
// Directed bench for sequence_transmitter: GAP=1 instance plus a GAP=0 instance,
// expected per-cycle waveforms written out by hand (leftmost bit = first cycle).
module tb_sequence_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  sequence_transmitter_if #(.CNT_W(4)) bus ();
  sequence_transmitter_if #(.CNT_W(4)) bus0 ();

  sequence_transmitter #(
    .PAT_LEN(6), .PATTERN(6'b110110), .GAP(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  sequence_transmitter #(
    .PAT_LEN(6), .PATTERN(6'b110110), .GAP(0), .CNT_W(4)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Advance n cycles; start/abort are one-shot and cleared after the first edge.
  task automatic run(input string tag, input bit sel0, input int n,
                     input logic [31:0] es, input logic [31:0] ev,
                     input logic [31:0] eb, input logic [31:0] ed);
    for (int i = 0; i < n; i++) begin
      int k;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus0.start = 1'b0;
      bus0.abort = 1'b0;
      k = n - 1 - i;
      if (sel0) begin
        chk($sformatf("%s c%0d seq", tag, i + 1), bus0.seq, es[k]);
        chk($sformatf("%s c%0d seq_valid", tag, i + 1), bus0.seq_valid, ev[k]);
        chk($sformatf("%s c%0d busy", tag, i + 1), bus0.busy, eb[k]);
        chk($sformatf("%s c%0d done", tag, i + 1), bus0.done, ed[k]);
      end else begin
        chk($sformatf("%s c%0d seq", tag, i + 1), bus.seq, es[k]);
        chk($sformatf("%s c%0d seq_valid", tag, i + 1), bus.seq_valid, ev[k]);
        chk($sformatf("%s c%0d busy", tag, i + 1), bus.busy, eb[k]);
        chk($sformatf("%s c%0d done", tag, i + 1), bus.done, ed[k]);
      end
    end
  endtask

  initial begin
    bus.start       = 1'b1;
    bus.repeat_cnt  = 4'd1;
    bus.abort       = 1'b0;
    bus0.start      = 1'b0;
    bus0.repeat_cnt = 4'd0;
    bus0.abort      = 1'b0;

    // Reset held with start high: nothing moves.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst seq", bus.seq, 1'b0);
    chk("rst seq_valid", bus.seq_valid, 1'b0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    bus.start = 1'b0;
    rst = 1'b1;
    run("idle", 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single frame.
    bus.start = 1'b1; bus.repeat_cnt = 4'd1;
    run("single", 0, 8, 8'b11011000, 8'b11111100, 8'b11111100, 8'b00000010);

    // Three frames, GAP=1; repeat_cnt changed after capture must not matter.
    bus.start = 1'b1; bus.repeat_cnt = 4'd3;
    run("triple", 0, 2, 2'b11, 2'b11, 2'b11, 2'b00);
    bus.repeat_cnt = 4'd0;
    run("triple", 0, 20, 20'b01100110110011011000, 20'b11110111111011111100,
        20'b11111111111111111100, 20'b00000000000000000010);

    // Back-to-back frames on the GAP=0 instance.
    bus0.start = 1'b1; bus0.repeat_cnt = 4'd2;
    run("gap0", 1, 14, 14'b11011011011000, 14'b11111111111100,
        14'b11111111111100, 14'b00000000000010);

    // Abort (with start high together) mid-frame, then a clean restart.
    bus.start = 1'b1; bus.repeat_cnt = 4'd2;
    run("abort", 0, 4, 4'b1101, 4'b1111, 4'b1111, 4'b0000);
    bus.abort = 1'b1; bus.start = 1'b1;
    run("abort idle", 0, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    bus.start = 1'b1; bus.repeat_cnt = 4'd1;
    run("restart", 0, 7, 7'b1101100, 7'b1111110, 7'b1111110, 7'b0000001);

    // Start while busy is ignored; still a single frame.
    bus.start = 1'b1; bus.repeat_cnt = 4'd1;
    run("ignore", 0, 3, 3'b110, 3'b111, 3'b111, 3'b000);
    bus.start = 1'b1; bus.repeat_cnt = 4'd3;
    run("ignore", 0, 5, 5'b11000, 5'b11100, 5'b11100, 5'b00010);

    // Start in the DONE cycle begins a frame immediately.
    bus.start = 1'b1; bus.repeat_cnt = 4'd1;
    run("back", 0, 7, 7'b1101100, 7'b1111110, 7'b1111110, 7'b0000001);
    bus.start = 1'b1; bus.repeat_cnt = 4'd1;
    run("back2", 0, 7, 7'b1101100, 7'b1111110, 7'b1111110, 7'b0000001);

    // Zero repeats: done only.
    bus.start = 1'b1; bus.repeat_cnt = 4'd0;
    run("zero", 0, 3, 3'b000, 3'b000, 3'b000, 3'b100);

    // Async reset between edges mid-frame.
    bus.start = 1'b1; bus.repeat_cnt = 4'd2;
    run("areset pre", 0, 3, 3'b110, 3'b111, 3'b111, 3'b000);
    #2 rst = 1'b0;
    #1;
    chk("areset seq", bus.seq, 1'b0);
    chk("areset seq_valid", bus.seq_valid, 1'b0);
    chk("areset busy", bus.busy, 1'b0);
    chk("areset done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run("areset post", 0, 3, 3'b000, 3'b000, 3'b000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
